// File: rtl/in128_out1536.sv
// ---------------------------------------------------------------------------
// in128_out1536
//   Packs a stream of IN_W-bit beats into RATIO-beat output words
//   (128 -> 1536 with the defaults). Beat k of a word is placed at
//   bits [k*IN_W +: IN_W], so beat 0 sits at the LSBs. A beat carrying
//   s_axis_tlast closes the word early and leaves the unwritten upper
//   lanes zero.
//
//   Buffering: one output register plus the accumulator. When a word
//   completes while the output register is stalled, the word stays in the
//   accumulator (acc_full) and input is paused until the output frees.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   s_axis_tdata   input beat (IN_W)
//   s_axis_tvalid  input beat valid
//   s_axis_tlast   last beat of packet, flushes the partial word
//   s_axis_tready  beat accepted when high together with tvalid (flop)
//   m_axis_tdata   assembled word (IN_W*RATIO)
//   m_axis_tbeats  number of valid beats in the word, 1..RATIO
//   m_axis_tlast   word ends a packet
//   m_axis_tvalid  output word valid
//   m_axis_tready  downstream accepts the word
// ---------------------------------------------------------------------------
module in128_out1536 #(
    parameter int IN_W  = 128,
    parameter int RATIO = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [IN_W*RATIO-1:0] m_axis_tdata,
    output logic [3:0]            m_axis_tbeats,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int OUT_W = IN_W * RATIO;

    logic [OUT_W-1:0] acc_reg, acc_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             acc_full_reg, acc_full_next;
    logic [3:0]       acc_beats_reg, acc_beats_next;
    logic             acc_last_reg, acc_last_next;
    logic             ready_reg, ready_next;
    logic [OUT_W-1:0] out_data_reg, out_data_next;
    logic [3:0]       out_beats_reg, out_beats_next;
    logic             out_last_reg, out_last_next;
    logic             out_valid_reg, out_valid_next;

    logic             accept;
    logic             complete;
    logic             slot_free;
    logic [OUT_W-1:0] word_merged;

    // Accumulator with the current beat dropped into lane cnt. Lanes above
    // cnt are still zero because acc is cleared whenever a word leaves it.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign word_merged[gi*IN_W +: IN_W] =
                (cnt_reg == 4'(gi)) ? s_axis_tdata : acc_reg[gi*IN_W +: IN_W];
        end
    endgenerate

    assign accept    = s_axis_tvalid & ready_reg;
    assign complete  = accept & ((cnt_reg == 4'(RATIO-1)) | s_axis_tlast);
    assign slot_free = ~out_valid_reg | m_axis_tready;

    always_comb begin
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        acc_full_next  = acc_full_reg;
        acc_beats_next = acc_beats_reg;
        acc_last_next  = acc_last_reg;
        out_data_next  = out_data_reg;
        out_beats_next = out_beats_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;

        if (acc_full_reg) begin
            // A held word implies the output register is occupied; it moves
            // across as soon as the current output is taken.
            if (m_axis_tready) begin
                out_data_next  = acc_reg;
                out_beats_next = acc_beats_reg;
                out_last_next  = acc_last_reg;
                out_valid_next = 1'b1;
                acc_next       = '0;
                acc_full_next  = 1'b0;
            end
        end else begin
            if (out_valid_reg && m_axis_tready) begin
                out_valid_next = 1'b0;
            end
            if (complete) begin
                cnt_next = 4'd0;
                if (slot_free) begin
                    out_data_next  = word_merged;
                    out_beats_next = cnt_reg + 4'd1;
                    out_last_next  = s_axis_tlast;
                    out_valid_next = 1'b1;
                    acc_next       = '0;
                end else begin
                    acc_next       = word_merged;
                    acc_beats_next = cnt_reg + 4'd1;
                    acc_last_next  = s_axis_tlast;
                    acc_full_next  = 1'b1;
                end
            end else if (accept) begin
                acc_next = word_merged;
                cnt_next = cnt_reg + 4'd1;
            end
        end

        // Ready is registered from the next-state of acc_full so it has no
        // combinational path from any input.
        ready_next = ~acc_full_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            cnt_reg       <= 4'd0;
            acc_full_reg  <= 1'b0;
            acc_beats_reg <= 4'd0;
            acc_last_reg  <= 1'b0;
            ready_reg     <= 1'b0;
            out_data_reg  <= '0;
            out_beats_reg <= 4'd0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            acc_full_reg  <= acc_full_next;
            acc_beats_reg <= acc_beats_next;
            acc_last_reg  <= acc_last_next;
            ready_reg     <= ready_next;
            out_data_reg  <= out_data_next;
            out_beats_reg <= out_beats_next;
            out_last_reg  <= out_last_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tbeats = out_beats_reg;
    assign m_axis_tlast  = out_last_reg;
    assign m_axis_tvalid = out_valid_reg;

endmodule
